wb_write_queue: RTL
===================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries (power of two, 2..16).
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 WrValid_i  input  1  producer offers a register write this cycle.
REQ-005 WrReg_i  input  5  destination register index of offered write.
REQ-006 WrData_i  input  32  data of offered write.
REQ-007 WrReady_o  output  1  queue can accept an offered write this cycle.
REQ-008 Hold_i  input  1  when high, no entry drains this cycle.
REQ-009 RegWrite_o  output  1  write-enable to register file write port.
REQ-010 WriteRegister_o  output  5  register file write index.
REQ-011 WriteData_o  output  32  register file write data.
REQ-012 LookupReg_i  input  5  register index probed for pending data.
REQ-013 LookupHit_o  output  1  a pending or in-flight write targets LookupReg_i.
REQ-014 LookupData_o  output  32  data of newest matching pending/in-flight write.
REQ-015 Count_o  output  $clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-016 Queue SHALL be FIFO of {reg[4:0], data[31:0]} with DEPTH entries, head/tail pointers wrapping modulo DEPTH.
REQ-017 WrReady_o SHALL equal (Count_o < DEPTH), combinational from current count only; a same-cycle drain SHALL NOT raise WrReady_o when full.
REQ-018 Accept SHALL occur at rising edge when WrValid_i && WrReady_o; accepted write with WrReg_i == 0 SHALL be discarded (handshake completes, no entry stored, count unchanged).
REQ-019 Drain SHALL occur at rising edge when Count_o > 0 and Hold_i == 0: head entry moves into output registers, RegWrite_o = 1 for exactly that following cycle.
REQ-020 If no drain at an edge, RegWrite_o SHALL be 0 for the following cycle; WriteRegister_o/WriteData_o SHALL retain last drained values.
REQ-021 An entry accepted at edge k SHALL NOT drain before edge k+1; minimum latency accept-to-RegWrite_o = 1 cycle.
REQ-022 Simultaneous accept and drain at one edge SHALL leave Count_o unchanged; accept only +1; drain only -1.
REQ-023 Drain order SHALL equal accept order; no reordering, no coalescing of same-register writes.
REQ-024 Lookup SHALL be combinational over all occupied entries plus the output register when RegWrite_o == 1; LookupReg_i == 0 SHALL always give LookupHit_o = 0.
REQ-025 Lookup priority: newest queue entry first, then oldest queue entry, then output register; LookupData_o SHALL be 0 when LookupHit_o == 0.
REQ-026 Output register is in-flight: register file commits it on the falling edge within that cycle, so it SHALL be included in lookup for the whole cycle.
REQ-027 Count_o SHALL never exceed DEPTH nor underflow; drain with Count_o == 0 SHALL do nothing.
REQ-028 Hold_i SHALL NOT affect acceptance.

Reset
REQ-029 rst_i low SHALL immediately clear count, head and tail pointers, RegWrite_o, WriteRegister_o (0), WriteData_o (0); WrReady_o = 1, LookupHit_o = 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending and in-flight entries; no register write SHALL issue after reset assertion.
REQ-031 Entry storage contents need not be cleared; occupancy alone governs validity.

Verification
REQ-032 Single write: accept {r5, 0xDEADBEEF}, Hold_i = 0 -> next cycle RegWrite_o = 1, WriteRegister_o = 5, WriteData_o = 0xDEADBEEF; following cycle RegWrite_o = 0.
REQ-033 Fill: Hold_i = 1, push r1..r4 (data 0x11..0x44), offer r6 -> Count_o = 4, WrReady_o = 0, r6 not accepted; release Hold_i -> writes r1,r2,r3,r4 on four consecutive cycles.
REQ-034 Lookup: queue holds r7=0x1, r7=0x2, Hold_i = 1, LookupReg_i = 7 -> LookupHit_o = 1, LookupData_o = 0x2; LookupReg_i = 0 -> LookupHit_o = 0.
REQ-035 Zero register: push r0 with 0xFFFFFFFF -> handshake completes, Count_o stays 0, RegWrite_o never asserted.
REQ-036 Simultaneous: Count_o = 2, push and drain same edge -> Count_o = 2, drained entry is oldest.
REQ-037 Reset mid-drain: Count_o = 3, RegWrite_o = 1, pull rst_i low between edges -> RegWrite_o = 0 immediately, Count_o = 0, no writes after release.

Source files
------------

// File: rtl/wb_write_queue_if.sv
// Write-queue bus: producer offer, hold, register-file write port,
// lookup probe and occupancy count.
interface wb_write_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          WrValid_i;
  logic [4:0]    WrReg_i;
  logic [31:0]   WrData_i;
  logic          WrReady_o;
  logic          Hold_i;
  logic          RegWrite_o;
  logic [4:0]    WriteRegister_o;
  logic [31:0]   WriteData_o;
  logic [4:0]    LookupReg_i;
  logic          LookupHit_o;
  logic [31:0]   LookupData_o;
  logic [CW-1:0] Count_o;

  modport master (
    output WrValid_i, WrReg_i, WrData_i,
    output Hold_i, LookupReg_i,
    input  WrReady_o, RegWrite_o,
    input  WriteRegister_o, WriteData_o,
    input  LookupHit_o, LookupData_o,
    input  Count_o
  );

  modport slave (
    input  WrValid_i, WrReg_i, WrData_i,
    input  Hold_i, LookupReg_i,
    output WrReady_o, RegWrite_o,
    output WriteRegister_o, WriteData_o,
    output LookupHit_o, LookupData_o,
    output Count_o
  );
endinterface

// File: rtl/wb_write_queue.sv
// Pending register-write FIFO with in-flight output stage and lookup.
// Ports: clk_i, rst_i (async active-low), bus (wb_write_queue_if.slave).
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_write_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    reg_q [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          wr_en;
  logic [4:0]    wr_reg;
  logic [31:0]   wr_dat;
  logic          ready;
  logic          push;
  logic          pop;
  logic          hit;
  logic [31:0]   hit_dat;
  logic [AW-1:0] idx;

  assign ready = count < CW'(DEPTH);
  // r0 writes complete the handshake but are never stored
  assign push  = bus.WrValid_i && ready &&
                 (bus.WrReg_i != 5'd0);
  assign pop   = (count != '0) && !bus.Hold_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      reg_q[tail] <= bus.WrReg_i;
      dat_q[tail] <= bus.WrData_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wr_en  <= 1'b0;
      wr_reg <= 5'd0;
      wr_dat <= 32'd0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        wr_reg <= reg_q[head];
        wr_dat <= dat_q[head];
        head   <= head + 1'b1;
      end
      if (push)
        tail <= tail + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Lowest priority first: in-flight stage, then
  // queue oldest to newest so the newest match wins.
  always_comb begin
    hit     = 1'b0;
    hit_dat = 32'd0;
    idx     = '0;
    if (wr_en && wr_reg == bus.LookupReg_i) begin
      hit     = 1'b1;
      hit_dat = wr_dat;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count &&
          reg_q[idx] == bus.LookupReg_i) begin
        hit     = 1'b1;
        hit_dat = dat_q[idx];
      end
    end
    if (bus.LookupReg_i == 5'd0) begin
      hit     = 1'b0;
      hit_dat = 32'd0;
    end
  end

  assign bus.WrReady_o       = ready;
  assign bus.RegWrite_o      = wr_en;
  assign bus.WriteRegister_o = wr_reg;
  assign bus.WriteData_o     = wr_dat;
  assign bus.LookupHit_o     = hit;
  assign bus.LookupData_o    = hit_dat;
  assign bus.Count_o         = count;
endmodule
